// File: rtl/life_datapath.sv
// One Game-of-Life generation on a non-wrapping 8x8 board.
// Next state is combinational; a single async-clear register holds the result.
module life_datapath (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] grid,
  output logic [63:0] grid_evolve
);

  // Board framed by a dead border so edge cells need no special case.
  logic [9:0] prow [10];
  logic [63:0] next_grid;

  assign prow[0] = '0;
  assign prow[9] = '0;

  for (genvar i = 0; i < 8; i++) begin : g_pad
    assign prow[i+1] = {1'b0, grid[8*i +: 8], 1'b0};
  end

  for (genvar r = 0; r < 8; r++) begin : g_row
    for (genvar c = 0; c < 8; c++) begin : g_col
      logic [3:0] cnt;
      logic       live;

      assign cnt = {3'b0, prow[r][c]}
                 + {3'b0, prow[r][c+1]}
                 + {3'b0, prow[r][c+2]}
                 + {3'b0, prow[r+1][c]}
                 + {3'b0, prow[r+1][c+2]}
                 + {3'b0, prow[r+2][c]}
                 + {3'b0, prow[r+2][c+1]}
                 + {3'b0, prow[r+2][c+2]};

      assign live = grid[8*r+c];

      assign next_grid[8*r+c] =
        (cnt == 4'd3) | (live & (cnt == 4'd2));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) grid_evolve <= '0;
    else        grid_evolve <= next_grid;
  end

endmodule

// File: tb/tb_life_datapath.sv
// Directed-vector bench for life_datapath.
// Expected boards are hand-computed constants.
module tb_life_datapath;

  logic        clk;
  logic        reset;
  logic [63:0] grid;
  logic [63:0] grid_evolve;

  int tests;
  int fails;

  localparam logic [63:0] FULL   = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] CORNER = 64'h8100_0000_0000_0081;
  localparam logic [63:0] BLK_H  = 64'h0000_0000_1C00_0000;
  localparam logic [63:0] BLK_V  = 64'h0000_0008_0808_0000;
  localparam logic [63:0] SPARSE = 64'h0000_0000_0011_1000;
  localparam logic [63:0] EDGE3  = 64'h0000_0000_0000_0007;
  localparam logic [63:0] EDGE_N = 64'h0000_0000_0000_0202;
  localparam logic [63:0] BLOCK  = 64'h0000_0000_0000_0303;

  life_datapath dut (
    .clk         (clk),
    .reset       (reset),
    .grid        (grid),
    .grid_evolve (grid_evolve)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag,
                      input logic [63:0] g,
                      input logic [63:0] exp);
    grid = g;
    @(posedge clk);
    #1;
    check(tag, grid_evolve, exp);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b0;
    grid  = FULL;

    #3;
    check("reset_before_edge", grid_evolve, 64'h0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_held_over_edges", grid_evolve, 64'h0);

    @(negedge clk);
    reset = 1'b1;
    #1;
    check("release_no_edge", grid_evolve, 64'h0);
    @(posedge clk);
    #1;
    check("full_to_corners", grid_evolve, CORNER);

    step("blinker_h_to_v", BLK_H, BLK_V);
    step("blinker_v_to_h", BLK_V, BLK_H);

    step("sparse_dies", SPARSE, 64'h0);
    step("empty_stays_0", 64'h0, 64'h0);
    step("empty_stays_1", 64'h0, 64'h0);

    step("edge_no_wrap", EDGE3, EDGE_N);
    check("edge_bit57", {63'h0, grid_evolve[57]}, 64'h0);

    step("block_0", BLOCK, BLOCK);
    step("block_1", BLOCK, BLOCK);
    step("block_2", BLOCK, BLOCK);

    // Input glitch between edges must not matter.
    grid = FULL;
    #2;
    step("glitch_ignored", EDGE3, EDGE_N);

    step("run_0", BLK_H, BLK_V);
    step("run_1", BLK_V, BLK_H);
    step("run_2", BLK_H, BLK_V);

    #2;
    reset = 1'b0;
    #1;
    check("midrun_reset_async", grid_evolve, 64'h0);
    grid = BLK_H;
    @(posedge clk);
    #1;
    check("midrun_reset_held", grid_evolve, 64'h0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("resume_after_reset", grid_evolve, BLK_V);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
